// File: rtl/hasti_sram_slave.sv
// AHB-Lite (HASTI) SRAM slave with optional wait states, byte-lane writes,
// write-to-read forwarding and the two-cycle ERROR response.
module hasti_sram_slave #(
  parameter int ADDR_WIDTH  = 12,
  parameter int WAIT_STATES = 0
) (
  input  logic        hclk,
  input  logic        hresetn,
  input  logic        hsel,
  input  logic [31:0] haddr,
  input  logic        hwrite,
  input  logic [2:0]  hsize,
  input  logic [2:0]  hburst,
  input  logic [3:0]  hprot,
  input  logic [1:0]  htrans,
  input  logic        hmastlock,
  input  logic [31:0] hwdata,
  input  logic        hready,
  output logic [31:0] hrdata,
  output logic        hreadyout,
  output logic        hresp,
  output logic [2:0]  o_dbg_state
);

  localparam int IW    = ADDR_WIDTH - 2;
  localparam int DEPTH = 1 << IW;
  localparam logic [3:0] WS_INIT = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_WAIT = 3'd1,
    S_DATA = 3'd2,
    S_ERR1 = 3'd3,
    S_ERR2 = 3'd4
  } state_t;

  state_t          r_state;
  state_t          w_state_next;
  logic [3:0]      r_cnt;
  logic            r_write;
  logic            r_read;
  logic [IW-1:0]   r_waddr;
  logic [3:0]      r_strb;
  logic [31:0]     r_rd_word;
  logic [31:0]     r_hold;
  logic [31:0]     r_mem [DEPTH];

  logic            w_accept;
  logic            w_addr_phase;
  logic            w_legal;
  logic            w_take;
  logic            w_commit;
  logic [IW-1:0]   w_idx;
  logic [3:0]      w_strb;
  logic [31:0]     w_rd_fwd;
  logic            w_unused;

  assign w_unused = ^{hburst, hprot, hmastlock, htrans[0], haddr[31:ADDR_WIDTH]};

  // Valid/ready: an address phase is taken when hsel & hready & htrans[1];
  // the data phase completes on the edge where hreadyout is high.
  assign w_accept     = hsel & hready & htrans[1];
  assign w_addr_phase = (r_state == S_IDLE) || (r_state == S_DATA) || (r_state == S_ERR2);
  assign w_take       = w_addr_phase & w_accept & w_legal;
  assign w_idx        = haddr[ADDR_WIDTH-1:2];
  assign w_commit     = hresetn & (r_state == S_DATA) & r_write;

  always_comb begin
    case (hsize)
      3'd0:    w_legal = 1'b1;
      3'd1:    w_legal = ~haddr[0];
      3'd2:    w_legal = (haddr[1:0] == 2'b00);
      default: w_legal = 1'b0;
    endcase
  end

  always_comb begin
    case (hsize[1:0])
      2'd0:    w_strb = 4'b0001 << haddr[1:0];
      2'd1:    w_strb = haddr[1] ? 4'b1100 : 4'b0011;
      default: w_strb = 4'b1111;
    endcase
  end

  // A read taken while a write to the same word finishes sees the new lanes.
  always_comb begin
    w_rd_fwd = r_mem[w_idx];
    for (int b = 0; b < 4; b++) begin
      if (w_commit && (r_waddr == w_idx) && r_strb[b]) begin
        w_rd_fwd[8*b +: 8] = hwdata[8*b +: 8];
      end
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_WAIT: begin
        if (r_cnt == 4'd0) w_state_next = S_DATA;
      end
      S_ERR1: w_state_next = S_ERR2;
      default: begin
        if (w_accept) begin
          if (!w_legal)             w_state_next = S_ERR1;
          else if (WAIT_STATES > 0) w_state_next = S_WAIT;
          else                      w_state_next = S_DATA;
        end else begin
          w_state_next = S_IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge hclk) begin
    if (!hresetn) begin
      r_state   <= S_IDLE;
      r_cnt     <= 4'd0;
      r_write   <= 1'b0;
      r_read    <= 1'b0;
      r_waddr   <= '0;
      r_strb    <= 4'd0;
      r_rd_word <= 32'd0;
      r_hold    <= 32'd0;
    end else begin
      r_state <= w_state_next;
      if ((r_state == S_WAIT) && (r_cnt != 4'd0)) r_cnt <= r_cnt - 4'd1;
      if ((r_state == S_DATA) && r_read) r_hold <= r_rd_word;
      if (w_addr_phase) begin
        r_write <= w_take & hwrite;
        r_read  <= w_take & ~hwrite;
        if (w_take) begin
          r_cnt   <= WS_INIT;
          r_waddr <= w_idx;
          r_strb  <= w_strb;
          if (!hwrite) r_rd_word <= w_rd_fwd;
        end
      end
    end
  end

  // Memory contents survive reset; only the commit is gated by it.
  always_ff @(posedge hclk) begin
    if (w_commit) begin
      for (int b = 0; b < 4; b++) begin
        if (r_strb[b]) r_mem[r_waddr][8*b +: 8] <= hwdata[8*b +: 8];
      end
    end
  end

  assign hrdata      = ((r_state == S_DATA) && r_read) ? r_rd_word : r_hold;
  assign hreadyout   = (r_state != S_WAIT) && (r_state != S_ERR1);
  assign hresp       = (r_state == S_ERR1) || (r_state == S_ERR2);
  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_hasti_sram_slave.sv
// Bench for hasti_sram_slave: three instances (0, 3 and 2 wait states) driven
// by a pipelined AHB-Lite master against a byte-addressed memory model.
module tb_hasti_sram_slave;

  localparam int NI = 3;

  typedef struct {
    logic        sel;
    logic [1:0]  trans;
    logic        wr;
    logic [2:0]  size;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        rst;
  } xfer_t;

  logic        clk;
  logic        hresetn   [NI];
  logic        hsel      [NI];
  logic [31:0] haddr     [NI];
  logic        hwrite    [NI];
  logic [2:0]  hsize     [NI];
  logic [2:0]  hburst    [NI];
  logic [3:0]  hprot     [NI];
  logic [1:0]  htrans    [NI];
  logic        hmastlock [NI];
  logic [31:0] hwdata    [NI];
  logic        hready    [NI];
  logic [31:0] hrdata    [NI];
  logic        hreadyout [NI];
  logic        hresp     [NI];
  logic [2:0]  unused_dbg [NI];

  int n_checks = 0;
  int n_errors = 0;

  // scoreboard / master state
  logic [31:0] exp_q[$];
  xfer_t       q[$];
  xfer_t       ap;
  logic        ap_v;
  xfer_t       dp;
  logic        dp_v;
  logic        dp_ill;
  int          dp_age;
  logic [31:0] last_rdata;
  int          cur_k;
  logic [7:0]  mb [NI][4096];

  // clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  for (genvar g = 0; g < NI; g++) begin : g_dut
    assign hready[g] = hreadyout[g];
    hasti_sram_slave #(
      .ADDR_WIDTH (12),
      .WAIT_STATES((g == 0) ? 0 : ((g == 1) ? 3 : 2))
    ) u_dut (
      .hclk       (clk),
      .hresetn    (hresetn[g]),
      .hsel       (hsel[g]),
      .haddr      (haddr[g]),
      .hwrite     (hwrite[g]),
      .hsize      (hsize[g]),
      .hburst     (hburst[g]),
      .hprot      (hprot[g]),
      .htrans     (htrans[g]),
      .hmastlock  (hmastlock[g]),
      .hwdata     (hwdata[g]),
      .hready     (hready[g]),
      .hrdata     (hrdata[g]),
      .hreadyout  (hreadyout[g]),
      .hresp      (hresp[g]),
      .o_dbg_state(unused_dbg[g])
    );
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s inst=%0d got=%h exp=%h t=%0t", tag, cur_k, got, exp, $time);
    end
  endtask

  function automatic int ws_of(input int k);
    case (k)
      0:       return 0;
      1:       return 3;
      default: return 2;
    endcase
  endfunction

  function automatic logic illegal(input logic [2:0] s, input logic [31:0] a);
    return (s >= 3'd3) || (s == 3'd1 && a[0]) || (s == 3'd2 && a[1:0] != 2'b00);
  endfunction

  // reference model: byte-addressed memory, aliased on the low 12 address bits
  task automatic model_write(input logic [31:0] a, input logic [2:0] s, input logic [31:0] d);
    int base;
    base = int'(a[11:0]);
    for (int i = 0; i < (1 << s); i++) begin
      mb[cur_k][base + i] = d[8*((base + i) % 4) +: 8];
    end
  endtask

  function automatic logic [31:0] model_word(input logic [31:0] a);
    int base;
    base = int'(a[11:0]) & ~3;
    return {mb[cur_k][base+3], mb[cur_k][base+2], mb[cur_k][base+1], mb[cur_k][base]};
  endfunction

  function automatic xfer_t mk(input logic wr, input logic [2:0] sz,
                               input logic [31:0] a, input logic [31:0] d);
    xfer_t x;
    x.sel = 1'b1; x.trans = 2'd2; x.wr = wr; x.size = sz;
    x.addr = a; x.wdata = d; x.rst = 1'b0;
    return x;
  endfunction

  task automatic accept(input xfer_t x);
    dp = x; dp_v = 1'b1; dp_age = 0;
    dp_ill = illegal(x.size, x.addr);
    if (!dp_ill) begin
      if (x.wr && !x.rst) model_write(x.addr, x.size, x.wdata);
      if (!x.wr) exp_q.push_back(model_word(x.addr));
    end
  endtask

  task automatic drive_ap();
    if (ap_v) begin
      hsel[cur_k] = ap.sel; htrans[cur_k] = ap.trans; hwrite[cur_k] = ap.wr;
      hsize[cur_k] = ap.size; haddr[cur_k] = ap.addr;
    end else begin
      hsel[cur_k] = 1'b0; htrans[cur_k] = 2'd0; hwrite[cur_k] = 1'b0;
      hsize[cur_k] = 3'd0; haddr[cur_k] = $urandom();
    end
  endtask

  // driver: one bus cycle, observed and driven at the falling edge
  task automatic step();
    logic rdy, rsp, exp_rdy;
    logic [31:0] rd, w;
    @(negedge clk);
    rdy = hreadyout[cur_k]; rsp = hresp[cur_k]; rd = hrdata[cur_k];
    hresetn[cur_k] = 1'b1;
    if (dp_v) begin
      exp_rdy = dp_ill ? (dp_age >= 1) : (dp_age >= ws_of(cur_k));
      check("hreadyout", {31'd0, rdy}, {31'd0, exp_rdy});
      check("hresp", {31'd0, rsp}, {31'd0, dp_ill});
      if (rdy && !dp_ill && !dp.wr) begin
        if (exp_q.size() == 0) begin
          check("exp_q_underflow", 32'd1, 32'd0);
        end else begin
          w = exp_q.pop_front();
          check("hrdata", rd, w);
          last_rdata = w;
        end
      end else begin
        check("hrdata_hold", rd, last_rdata);
      end
    end else begin
      check("idle_hreadyout", {31'd0, rdy}, 32'd1);
      check("idle_hresp", {31'd0, rsp}, 32'd0);
      check("idle_hrdata_hold", rd, last_rdata);
    end
    hwdata[cur_k]    = (dp_v && dp.wr) ? dp.wdata : $urandom();
    hburst[cur_k]    = 3'($urandom_range(0, 7));
    hprot[cur_k]     = 4'($urandom_range(0, 15));
    hmastlock[cur_k] = 1'($urandom_range(0, 1));
    if (!ap_v && q.size() != 0) begin
      ap = q.pop_front();
      ap_v = 1'b1;
    end
    drive_ap();
    if (dp_v && dp.rst && !rdy) begin
      hresetn[cur_k] = 1'b0;
      dp_v = 1'b0;
      last_rdata = 32'd0;
    end else if (rdy) begin
      dp_v = 1'b0;
      if (ap_v) begin
        if (ap.sel && ap.trans[1]) accept(ap);
        ap_v = 1'b0;
      end
    end else begin
      dp_age++;
      if (dp_age > 20) begin
        check("data_phase_timeout", 32'd1, 32'd0);
        dp_v = 1'b0;
      end
    end
  endtask

  task automatic drain();
    for (int i = 0; i < 3000 && (q.size() != 0 || ap_v || dp_v); i++) step();
    if (q.size() != 0 || ap_v || dp_v) check("drain_timeout", 32'd1, 32'd0);
    step();
    step();
  endtask

  task automatic start_inst(input int k);
    cur_k = k; ap_v = 1'b0; dp_v = 1'b0; dp_age = 0; dp_ill = 1'b0;
    last_rdata = 32'd0;
    exp_q.delete();
    q.delete();
  endtask

  task automatic prefill();
    for (int w = 0; w < 16; w++) begin
      q.push_back(mk(1'b1, 3'd2, ($urandom() & 32'hFFFF_F000) | 32'(w * 4), $urandom()));
    end
  endtask

  task automatic gen_random(input int n);
    for (int i = 0; i < n; i++) begin
      xfer_t x;
      int r;
      logic [31:0] lo;
      x.sel = ($urandom_range(0, 9) != 0);
      r = $urandom_range(0, 9);
      x.trans = (r == 0) ? 2'd0 : ((r == 1) ? 2'd1 : 2'($urandom_range(2, 3)));
      x.wr = 1'($urandom_range(0, 1));
      x.size = ($urandom_range(0, 9) == 0) ? 3'($urandom_range(3, 7)) : 3'($urandom_range(0, 2));
      lo = 32'($urandom_range(0, 63));
      if ($urandom_range(0, 7) != 0 && x.size <= 3'd2) lo = lo & ~((32'd1 << x.size) - 32'd1);
      x.addr = ($urandom() & 32'hFFFF_F000) | lo;
      x.wdata = $urandom();
      x.rst = 1'b0;
      q.push_back(x);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired t=%0t", $time);
    $fatal(1);
  end

  initial begin
    for (int k = 0; k < NI; k++) begin
      hresetn[k] = 1'b0; hsel[k] = 1'b1; haddr[k] = 32'h10; hwrite[k] = 1'b1;
      hsize[k] = 3'd2; hburst[k] = 3'd0; hprot[k] = 4'd0; htrans[k] = 2'd2;
      hmastlock[k] = 1'b0; hwdata[k] = 32'hFFFF_FFFF;
    end
    // reset held two cycles with NONSEQ on the bus
    for (int c = 0; c < 2; c++) begin
      @(posedge clk);
      @(negedge clk);
      for (int k = 0; k < NI; k++) begin
        cur_k = k;
        check("rst_hreadyout", {31'd0, hreadyout[k]}, 32'd1);
        check("rst_hresp", {31'd0, hresp[k]}, 32'd0);
        check("rst_hrdata", hrdata[k], 32'd0);
      end
    end
    for (int k = 0; k < NI; k++) begin
      hresetn[k] = 1'b1; hsel[k] = 1'b0; htrans[k] = 2'd0;
    end

    // zero wait states: forwarding, byte/half lanes, error response
    start_inst(0);
    prefill();
    q.push_back(mk(1'b1, 3'd2, 32'h10, 32'hDEAD_BEEF));
    q.push_back(mk(1'b0, 3'd2, 32'h10, 32'h0));
    q.push_back(mk(1'b1, 3'd2, 32'h10, 32'h1122_3344));
    q.push_back(mk(1'b1, 3'd0, 32'h13, 32'hAA00_0000));
    q.push_back(mk(1'b0, 3'd2, 32'h10, 32'h0));
    q.push_back(mk(1'b1, 3'd1, 32'h12, 32'h5566_0000));
    q.push_back(mk(1'b0, 3'd2, 32'h10, 32'h0));
    q.push_back(mk(1'b0, 3'd2, 32'h02, 32'h0));
    q.push_back(mk(1'b0, 3'd2, 32'h00, 32'h0));
    q.push_back(mk(1'b1, 3'd2, 32'h11, 32'hFFFF_FFFF));
    q.push_back(mk(1'b1, 3'd1, 32'h13, 32'hFFFF_FFFF));
    q.push_back(mk(1'b0, 3'd2, 32'h10, 32'h0));
    q.push_back(mk(1'b0, 3'd3, 32'h14, 32'h0));
    q.push_back(mk(1'b0, 3'd2, 32'h1000_0010, 32'h0));
    drain();
    gen_random(250);
    drain();
    check("exp_q_leftover_0", 32'(exp_q.size()), 32'd0);

    // three wait states
    start_inst(1);
    prefill();
    q.push_back(mk(1'b0, 3'd2, 32'h20, 32'h0));
    q.push_back(mk(1'b1, 3'd0, 32'h21, 32'h0000_7700));
    q.push_back(mk(1'b0, 3'd2, 32'h20, 32'h0));
    q.push_back(mk(1'b0, 3'd1, 32'h21, 32'h0));
    q.push_back(mk(1'b0, 3'd2, 32'h24, 32'h0));
    drain();
    gen_random(150);
    drain();
    check("exp_q_leftover_1", 32'(exp_q.size()), 32'd0);

    // two wait states, reset during a write's wait
    start_inst(2);
    prefill();
    begin
      xfer_t x;
      x = mk(1'b1, 3'd2, 32'h08, 32'hCAFE_F00D);
      x.rst = 1'b1;
      q.push_back(x);
    end
    q.push_back(mk(1'b0, 3'd2, 32'h08, 32'h0));
    drain();
    gen_random(150);
    drain();
    check("exp_q_leftover_2", 32'(exp_q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
